midi_writer: RTL and testbench

- Serial MIDI transmitter: accepts one note event per handshake, builds a 3-byte Note On/Note Off message, serializes it 8N1, LSB first, on midi_out.
- Bit timing matches the midireader receiver: 128 clocks per bit at the default parameter, so a writer-to-reader loopback round-trips.
- Sits between the note-generation logic and the MIDI output pin.

---
 rtl/midi_writer.sv | 89 ++++++++
 tb/tb_midi_writer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/midi_writer.sv
// midi_writer: 8N1 MIDI Note On/Off transmitter; optional running status via MIDI_RUNNING_STATUS_EN
module midi_writer #(
  parameter int CLKS_PER_BIT = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ev_valid,
  output logic       ev_ready,
  input  logic       ev_on,
  input  logic [3:0] ev_chan,
  input  logic [6:0] ev_note,
  input  logic [6:0] ev_vel,
  output logic       midi_out,
  output logic       busy,
  output logic       byte_done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [1:0] byte_idx;
  logic [7:0] st_b, nt_b, vl_b, cur, ev_st;
  logic wrap, accept, skip;
  assign ev_st = {ev_on ? 4'h9 : 4'h8, ev_chan};
  assign accept = ev_valid && ev_ready;
  assign wrap = cnt == LAST;
  assign ev_ready = state == IDLE;
  assign busy = !ev_ready;
  assign cur = byte_idx == 2'd0 ? st_b : byte_idx == 2'd1 ? nt_b : vl_b;
`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0] last_st;
  assign skip = ev_st == last_st;
  // remember the status of every message that will put a status byte on the line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_st <= 8'h00;
    else if (accept && !skip) last_st <= ev_st;
  end
`else
  assign skip = 1'b0;
`endif
  // next state and line/pulse decode from the registered frame position
  always_comb begin
    state_n = state;
    midi_out = 1'b1;
    byte_done = 1'b0;
    unique case (state)
      IDLE:  state_n = ev_valid ? START : IDLE;
      START: begin
        state_n = wrap ? DATA : START;
        midi_out = 1'b0;
      end
      DATA: begin
        state_n = (wrap && bit_idx == 3'd7) ? STOP : DATA;
        midi_out = cur[bit_idx];
      end
      STOP: begin
        state_n = wrap ? (byte_idx == 2'd2 ? IDLE : START) : STOP;
        byte_done = wrap;
      end
      default: state_n = IDLE;
    endcase
  end
  // frame position counters and the captured message bytes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      byte_idx <= '0;
      st_b <= '0;
      nt_b <= '0;
      vl_b <= '0;
    end else begin
      state <= state_n;
      cnt <= (state == IDLE || wrap) ? '0 : cnt + 1'b1;
      bit_idx <= state != DATA ? 3'd0 : wrap ? bit_idx + 3'd1 : bit_idx;
      if (accept) begin
        st_b <= ev_st;
        nt_b <= {1'b0, ev_note};
        vl_b <= {1'b0, ev_vel};
        byte_idx <= skip ? 2'd1 : 2'd0;
      end else if (state == STOP && wrap && byte_idx != 2'd2) begin
        byte_idx <= byte_idx + 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_midi_writer.sv
// tb_midi_writer: table-driven scoreboard bench decoding the serial line of midi_writer
module tb_midi_writer;
  localparam int CPB = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ev_valid = 1'b0;
  logic ev_on = 1'b0;
  logic [3:0] ev_chan = '0;
  logic [6:0] ev_note = '0;
  logic [6:0] ev_vel = '0;
  logic ev_ready, midi_out, busy, byte_done;
  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];

  typedef struct {
    logic on;
    logic [3:0] ch;
    logic [6:0] n;
    logic [6:0] v;
    logic [7:0] es;
    logic [7:0] en;
    logic [7:0] ev;
  } vec_t;
  vec_t tv[5];

  always #5 clk = ~clk;

  midi_writer #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_on(ev_on), .ev_chan(ev_chan), .ev_note(ev_note), .ev_vel(ev_vel),
    .midi_out(midi_out), .busy(busy), .byte_done(byte_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t t, input bit skip);
    ev_valid = 1'b1;
    ev_on = t.on;
    ev_chan = t.ch;
    ev_note = t.n;
    ev_vel = t.v;
    if (!skip) q.push_back(t.es);
    q.push_back(t.en);
    q.push_back(t.ev);
  endtask

  task automatic send(input vec_t t, input bit skip);
    int w = 0;
    while (!ev_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("ready_wait", ev_ready, 1'b1);
    drive(t, skip);
    @(posedge clk);
    #1;
    ev_valid = 1'b0;
    ev_on = 1'($urandom);
    ev_chan = 4'($urandom);
    ev_note = 7'($urandom);
    ev_vel = 7'($urandom);
  endtask

  task automatic expect_busy(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) chk("line_falls", midi_out, 1'b0);
      chk("busy_ready", {ev_ready, busy}, 2'b01);
    end
    @(negedge clk);
    chk("done_ready", {ev_ready, busy}, 2'b10);
    chk("idle_line", midi_out, 1'b1);
  endtask

  // line monitor: decodes each 8N1 frame, checks framing and byte_done, pops expected bytes
  initial begin
    int mph;
    logic [7:0] sh;
    logic [7:0] e;
    mph = -1;
    sh = '0;
    forever begin
      @(negedge clk);
      if (rst) mph = -1;
      else begin
        if (mph < 0 && !midi_out) mph = 0;
        chk("byte_done", byte_done, mph == 10 * CPB - 1);
        if (mph >= 0) begin
          if (mph == CPB / 2) chk("start_bit", midi_out, 1'b0);
          if (mph / CPB >= 1 && mph / CPB <= 8 && mph % CPB == CPB / 2) sh = {midi_out, sh[7:1]};
          if (mph == 9 * CPB + CPB / 2) chk("stop_bit", midi_out, 1'b1);
          if (mph == 10 * CPB - 1) begin
            if (q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL byte_extra: got %02h expected none", sh);
            end else begin
              e = q.pop_front();
              chk("byte", sh, e);
            end
            mph = -1;
          end else mph++;
        end
      end
    end
  end

  initial begin
    vec_t a, b, e, f;
    tv[0] = '{1'b1, 4'd0,  7'd60,   7'd100,  8'h90, 8'h3C, 8'h64};
    tv[1] = '{1'b0, 4'd5,  7'h45,   7'h40,   8'h85, 8'h45, 8'h40};
    tv[2] = '{1'b1, 4'd15, 7'h7F,   7'h00,   8'h9F, 8'h7F, 8'h00};
    tv[3] = '{1'b0, 4'd0,  7'h7F,   7'h7F,   8'h80, 8'h7F, 8'h7F};
    tv[4] = '{1'b1, 4'd9,  7'h55,   7'h2A,   8'h99, 8'h55, 8'h2A};
    a = '{1'b1, 4'd3, 7'h11, 7'h22, 8'h93, 8'h11, 8'h22};
    b = '{1'b0, 4'd3, 7'h33, 7'h44, 8'h83, 8'h33, 8'h44};
    e = '{1'b1, 4'd1, 7'h30, 7'h31, 8'h91, 8'h30, 8'h31};
    f = '{1'b1, 4'd1, 7'h5A, 7'h25, 8'h91, 8'h5A, 8'h25};
    #1;
    chk("rst_line", midi_out, 1'b1);
    chk("rst_ready", {ev_ready, busy, byte_done}, 3'b100);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      send(tv[i], 1'b0);
      expect_busy(120);
    end
    // back-to-back: second request held through the first frame with different fields
    send(a, 1'b0);
    drive(b, 1'b0);
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      chk("held_not_accepted", ev_ready, 1'b0);
    end
    @(negedge clk);
    chk("b2b_ready", ev_ready, 1'b1);
    @(posedge clk);
    #1;
    ev_valid = 1'b0;
    expect_busy(120);
    // reset during DATA of byte 1, with a request pending while reset is high
    send(e, 1'b0);
    repeat (50) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    drive(f, 1'b1);
    q.delete();
    #1;
    chk("rst_mid_line", midi_out, 1'b1);
    chk("rst_mid_flags", {ev_ready, busy, byte_done}, 3'b100);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wins_line", midi_out, 1'b1);
    chk("rst_wins_ready", ev_ready, 1'b1);
    ev_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {ev_ready, midi_out}, 2'b11);
    send(f, 1'b0);
    expect_busy(120);
`ifdef MIDI_RUNNING_STATUS_EN
    a = '{1'b1, 4'd2, 7'h40, 7'h50, 8'h92, 8'h40, 8'h50};
    b = '{1'b1, 4'd2, 7'h41, 7'h51, 8'h92, 8'h41, 8'h51};
    e = '{1'b0, 4'd2, 7'h40, 7'h00, 8'h82, 8'h40, 8'h00};
    send(a, 1'b0);
    expect_busy(120);
    send(b, 1'b1);
    expect_busy(80);
    send(e, 1'b0);
    expect_busy(120);
`endif
    repeat (5) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
